// File: rtl/npu_pkg.sv
// Shared NPU definitions: sequencer state encoding and control/config word bit positions.
// Also used by npu_core.
package npu_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StClear,
    StAccum,
    StFlush,
    StRelu,
    StPload,
    StDrain,
    StNext,
    StFinish
  } npu_state_e;

  // CON_SIG bit positions
  localparam int unsigned ConEnBufIn   = 15;
  localparam int unsigned ConClrBufIn  = 14;
  localparam int unsigned ConEnMac     = 13;
  localparam int unsigned ConRstMac    = 12;
  localparam int unsigned ConEnRelu    = 11;
  localparam int unsigned ConShiftOut  = 10;
  localparam int unsigned ConEnPisoOut = 9;
  localparam int unsigned ConClrPisoOut = 8;
  localparam int unsigned ConWrEn      = 7;

  // SSFR bit positions
  localparam int unsigned SsfrSelOutLsb = 13;
  localparam int unsigned SsfrBypassLsb = 11;
  localparam int unsigned SsfrEnComp    = 10;
  localparam int unsigned SsfrRstComp   = 9;
  localparam int unsigned SsfrEnFifo    = 8;
  localparam int unsigned SsfrRstFifo   = 7;

  // Index of the final tap; a tap count of 0 wraps to 255 and so encodes 256 taps.
  function automatic logic [7:0] last_tap(input logic [7:0] taps);
    return taps - 8'd1;
  endfunction

endpackage

// File: rtl/npu_seq_drain.sv
// Byte drain for the output PISO: counts bytes written to the FIFO and stalls on FIFO full.
module npu_seq_drain #(
  parameter int unsigned NumBytes = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic active_i,
  input  logic fifo_full_i,
  output logic wr_en_o,
  output logic shift_o,
  output logic last_o
);

  localparam int unsigned CntW = (NumBytes > 1) ? $clog2(NumBytes) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(NumBytes - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    wr_en_o = active_i & ~fifo_full_i;
    shift_o = wr_en_o & (cnt_q != LastIdx);
    last_o  = wr_en_o & (cnt_q == LastIdx);
    cnt_d   = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (shift_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/npu_sequencer.sv
// NPU job sequencer: steps the core through clear / accumulate / ReLU / PISO drain per neuron pair.
module npu_sequencer
  import npu_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 4
) (
  input  logic        CLKEXT,
  input  logic        RST,
  input  logic        START,
  input  logic [7:0]  CFG_TAPS,
  input  logic [7:0]  CFG_PAIRS,
  input  logic [2:0]  CFG_SEL_OUT,
  input  logic [1:0]  CFG_BYPASS,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        FIFO_FULL,
  output logic [15:0] CON_SIG,
  output logic [15:0] SSFR,
  output logic        BUSY,
  output logic        DONE
);

  npu_state_e state_d, state_q;
  logic [7:0] taps_q, pairs_q, tap_q, pair_q;
  logic       mac_pend_q;
  logic       accept, last_word;
  logic       drain_wr, drain_shift, drain_last;

  assign accept    = (state_q == StAccum) & IN_VALID;
  assign last_word = accept & (tap_q == last_tap(taps_q));

  npu_seq_drain #(
    .NumBytes (NUM_BYTES)
  ) u_drain (
    .clk_i       (CLKEXT),
    .rst_i       (RST),
    .load_i      (state_q == StPload),
    .active_i    (state_q == StDrain),
    .fifo_full_i (FIFO_FULL),
    .wr_en_o     (drain_wr),
    .shift_o     (drain_shift),
    .last_o      (drain_last)
  );

  // State, counters, latched config and the one-cycle buffer-to-MAC delay.
  always_ff @(posedge CLKEXT) begin
    if (RST) begin
      state_q    <= StIdle;
      taps_q     <= '0;
      pairs_q    <= '0;
      tap_q      <= '0;
      pair_q     <= '0;
      mac_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mac_pend_q <= accept;
      if (state_q == StIdle && START) begin
        taps_q  <= CFG_TAPS;
        pairs_q <= CFG_PAIRS;
        pair_q  <= '0;
      end
      if (state_q == StClear) begin
        tap_q <= '0;
      end else if (accept) begin
        tap_q <= tap_q + 8'd1;
      end
      if (state_q == StNext) begin
        pair_q <= pair_q + 8'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (START) state_d = StClear;
      StClear:  state_d = (pairs_q == 8'd0) ? StFinish : StAccum;
      StAccum:  if (last_word) state_d = StFlush;
      StFlush:  state_d = StRelu;
      StRelu:   state_d = StPload;
      StPload:  state_d = StDrain;
      StDrain:  if (drain_last) state_d = StNext;
      StNext:   state_d = (pair_q + 8'd1 == pairs_q) ? StFinish : StClear;
      StFinish: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    CON_SIG  = '0;
    SSFR     = '0;
    IN_READY = 1'b0;
    DONE     = 1'b0;
    BUSY     = (state_q != StIdle);
    unique case (state_q)
      StClear: begin
        CON_SIG[ConClrBufIn]   = 1'b1;
        CON_SIG[ConRstMac]     = 1'b1;
        CON_SIG[ConClrPisoOut] = 1'b1;
        SSFR[SsfrRstComp]      = (pair_q == 8'd0);
      end
      StAccum:  IN_READY = 1'b1;
      StRelu:   CON_SIG[ConEnRelu] = 1'b1;
      StPload:  CON_SIG[ConEnPisoOut] = 1'b1;
      StFinish: DONE = 1'b1;
      default:  ;
    endcase
    CON_SIG[ConEnBufIn]  = accept;
    CON_SIG[ConEnMac]    = mac_pend_q;
    CON_SIG[ConWrEn]     = drain_wr;
    CON_SIG[ConShiftOut] = drain_shift;
    SSFR[SsfrSelOutLsb +: 3] = CFG_SEL_OUT;
    SSFR[SsfrBypassLsb +: 2] = CFG_BYPASS;
    SSFR[SsfrEnComp]         = BUSY;
    SSFR[SsfrEnFifo]         = BUSY;
    SSFR[SsfrRstFifo]        = 1'b0;
  end

endmodule

// File: tb/tb_npu_sequencer.sv
// Self-checking bench for npu_sequencer: per-job event counts and DONE latency against a queued model.
module tb_npu_sequencer;

  localparam int NB = 4;

  logic        CLKEXT = 1'b0;
  logic        RST, START, IN_VALID, IN_READY, FIFO_FULL, BUSY, DONE;
  logic [7:0]  CFG_TAPS, CFG_PAIRS;
  logic [2:0]  CFG_SEL_OUT;
  logic [1:0]  CFG_BYPASS;
  logic [15:0] CON_SIG, SSFR;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int n_buf;
    int n_mac;
    int n_ready;
    int n_relu;
    int n_piso;
    int n_wr;
    int n_shift;
    int n_rstcomp;
    int done_k;
    int viol;
  } meas_t;

  meas_t exp_q[$];

  always #5 CLKEXT = ~CLKEXT;

  npu_sequencer #(
    .NUM_BYTES (NB)
  ) dut (
    .CLKEXT      (CLKEXT),
    .RST         (RST),
    .START       (START),
    .CFG_TAPS    (CFG_TAPS),
    .CFG_PAIRS   (CFG_PAIRS),
    .CFG_SEL_OUT (CFG_SEL_OUT),
    .CFG_BYPASS  (CFG_BYPASS),
    .IN_VALID    (IN_VALID),
    .IN_READY    (IN_READY),
    .FIFO_FULL   (FIFO_FULL),
    .CON_SIG     (CON_SIG),
    .SSFR        (SSFR),
    .BUSY        (BUSY),
    .DONE        (DONE)
  );

  // Expected job outcome. vmode 1 presents a word every other cycle starting on the first
  // ACCUM cycle, stretching ACCUM to 2*taps-1 cycles; stall is the number of FIFO-full cycles
  // that land inside DRAIN.
  function automatic meas_t model(input int taps, input int pairs, input int vmode,
                                  input int stall);
    meas_t e;
    int teff, acc;
    teff = (taps == 0) ? 256 : taps;
    acc  = (vmode != 0) ? 2 * teff - 1 : teff;
    e.n_buf     = teff * pairs;
    e.n_mac     = teff * pairs;
    e.n_ready   = acc * pairs;
    e.n_relu    = pairs;
    e.n_piso    = pairs;
    e.n_wr      = NB * pairs;
    e.n_shift   = (NB - 1) * pairs;
    e.n_rstcomp = 1;
    e.done_k    = (pairs == 0) ? 2 : pairs * (acc + NB + 5) + 1 + stall;
    e.viol      = 0;
    return e;
  endfunction

  // Drives one job from an idle DUT; k counts cycles from the START cycle (k=0).
  // Stops when DONE is seen, when k reaches abort_k (inputs for that cycle applied), or at the bound.
  task automatic run_job(input int taps, input int pairs, input int vmode, input int full_lo,
                         input int full_hi, input int start_hold, input int abort_k,
                         output meas_t m);
    logic prev_buf;
    m = '{default: 0};
    m.done_k = -1;
    prev_buf = 1'b0;
    @(posedge CLKEXT);
    #1;
    for (int k = 0; k < 2000; k++) begin
      if (k > 0) begin
        @(posedge CLKEXT);
        #1;
      end
      START     = (k <= start_hold);
      // Config is garbage after the START cycle; the DUT must have latched it.
      CFG_TAPS  = (k == 0) ? 8'(taps) : 8'hA5;
      CFG_PAIRS = (k == 0) ? 8'(pairs) : 8'h03;
      IN_VALID  = (vmode == 0) ? 1'b1 : (k % 2 == 0);
      FIFO_FULL = (k >= full_lo) && (k <= full_hi);
      if (k == abort_k) return;
      #1;
      if (CON_SIG[15]) m.n_buf++;
      if (CON_SIG[13]) m.n_mac++;
      if (IN_READY)    m.n_ready++;
      if (CON_SIG[11]) m.n_relu++;
      if (CON_SIG[9])  m.n_piso++;
      if (CON_SIG[7])  m.n_wr++;
      if (CON_SIG[10]) m.n_shift++;
      if (SSFR[9])     m.n_rstcomp++;
      if (CON_SIG[13] !== prev_buf) m.viol++;
      prev_buf = CON_SIG[15];
      if (CON_SIG[15] !== (IN_READY & IN_VALID)) m.viol++;
      if (FIFO_FULL && (CON_SIG[7] || CON_SIG[10])) m.viol++;
      if (CON_SIG[6:0] !== 7'd0 || SSFR[7:0] !== 8'd0) m.viol++;
      if (SSFR[10] !== BUSY || SSFR[8] !== BUSY) m.viol++;
      if (SSFR[15:11] !== {CFG_SEL_OUT, CFG_BYPASS}) m.viol++;
      if (BUSY !== (k != 0)) m.viol++;
      if (DONE === 1'b1) begin
        m.done_k = k;
        break;
      end
    end
    START     = 1'b0;
    IN_VALID  = 1'b0;
    FIFO_FULL = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; START = 1'b0; IN_VALID = 1'b1; FIFO_FULL = 1'b0;
    CFG_TAPS = 8'd3; CFG_PAIRS = 8'd1; CFG_SEL_OUT = 3'd5; CFG_BYPASS = 2'd2;
    repeat (2) @(posedge CLKEXT);
    #1;
    START = 1'b1;
    #1;
    n_checks++;
    if (CON_SIG !== 16'h0000) begin
      n_fail++; $display("FAIL reset_con_sig: got %h want 0000", CON_SIG);
    end
    n_checks++;
    if (SSFR !== 16'hB000) begin
      n_fail++; $display("FAIL reset_ssfr: got %h want b000", SSFR);
    end
    n_checks++;
    if ({IN_READY, BUSY, DONE} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b want 000", {IN_READY, BUSY, DONE});
    end
    CFG_SEL_OUT = 3'd2; CFG_BYPASS = 2'd1;
    #1;
    n_checks++;
    if (SSFR !== 16'h4800) begin
      n_fail++; $display("FAIL reset_ssfr_track: got %h want 4800", SSFR);
    end
    @(posedge CLKEXT);
    #1;
    n_checks++;
    if (BUSY !== 1'b0) begin
      n_fail++; $display("FAIL reset_start_ignored: busy=%b want 0", BUSY);
    end
    RST = 1'b0; START = 1'b0; IN_VALID = 1'b0;
    @(posedge CLKEXT);
    #1;
    n_checks++;
    if ({BUSY, CON_SIG} !== 17'd0) begin
      n_fail++; $display("FAIL reset_release_idle: got %h want 0", {BUSY, CON_SIG});
    end
  endtask

  task automatic test_basic();
    meas_t m, e;
    exp_q.push_back(model(3, 1, 0, 0));
    run_job(3, 1, 0, -1, -1, 0, -1, m);
    e = exp_q.pop_front();
    n_checks++;
    if (m.done_k !== e.done_k) begin
      n_fail++; $display("FAIL basic_done_k: got %0d want %0d", m.done_k, e.done_k);
    end
    n_checks++;
    if (m.n_buf !== e.n_buf || m.n_mac !== e.n_mac) begin
      n_fail++; $display("FAIL basic_buf_mac: got %0d/%0d want %0d/%0d", m.n_buf, m.n_mac,
                         e.n_buf, e.n_mac);
    end
    n_checks++;
    if (m.n_relu !== e.n_relu || m.n_piso !== e.n_piso) begin
      n_fail++; $display("FAIL basic_relu_piso: got %0d/%0d want %0d/%0d", m.n_relu, m.n_piso,
                         e.n_relu, e.n_piso);
    end
    n_checks++;
    if (m.n_wr !== e.n_wr || m.n_shift !== e.n_shift) begin
      n_fail++; $display("FAIL basic_wr_shift: got %0d/%0d want %0d/%0d", m.n_wr, m.n_shift,
                         e.n_wr, e.n_shift);
    end
    n_checks++;
    if (m.viol !== e.viol) begin
      n_fail++; $display("FAIL basic_cycle_rules: got %0d violations want %0d", m.viol, e.viol);
    end
  endtask

  task automatic test_toggle_valid();
    meas_t m, e;
    exp_q.push_back(model(4, 1, 1, 0));
    run_job(4, 1, 1, -1, -1, 0, -1, m);
    e = exp_q.pop_front();
    n_checks++;
    if (m.n_buf !== e.n_buf || m.n_mac !== e.n_mac) begin
      n_fail++; $display("FAIL toggle_buf_mac: got %0d/%0d want %0d/%0d", m.n_buf, m.n_mac,
                         e.n_buf, e.n_mac);
    end
    n_checks++;
    if (m.n_ready !== e.n_ready || m.done_k !== e.done_k) begin
      n_fail++; $display("FAIL toggle_ready_done: got %0d/%0d want %0d/%0d", m.n_ready, m.done_k,
                         e.n_ready, e.done_k);
    end
    n_checks++;
    if (m.viol !== e.viol) begin
      n_fail++; $display("FAIL toggle_cycle_rules: got %0d violations want %0d", m.viol, e.viol);
    end
  endtask

  task automatic test_back_to_back();
    meas_t m, e;
    // Two pairs, FIFO full for three cycles inside the first DRAIN, START held high mid-job.
    exp_q.push_back(model(3, 2, 0, 3));
    run_job(3, 2, 0, 9, 11, 5, -1, m);
    e = exp_q.pop_front();
    n_checks++;
    if (m.n_wr !== e.n_wr || m.n_shift !== e.n_shift) begin
      n_fail++; $display("FAIL b2b_wr_shift: got %0d/%0d want %0d/%0d", m.n_wr, m.n_shift,
                         e.n_wr, e.n_shift);
    end
    n_checks++;
    if (m.n_rstcomp !== e.n_rstcomp) begin
      n_fail++; $display("FAIL b2b_rst_comp: got %0d want %0d", m.n_rstcomp, e.n_rstcomp);
    end
    n_checks++;
    if (m.done_k !== e.done_k || m.n_mac !== e.n_mac) begin
      n_fail++; $display("FAIL b2b_done_mac: got %0d/%0d want %0d/%0d", m.done_k, m.n_mac,
                         e.done_k, e.n_mac);
    end
    n_checks++;
    if (m.viol !== e.viol) begin
      n_fail++; $display("FAIL b2b_cycle_rules: got %0d violations want %0d", m.viol, e.viol);
    end
  endtask

  task automatic test_empty_job();
    meas_t m, e;
    exp_q.push_back(model(5, 0, 0, 0));
    run_job(5, 0, 0, -1, -1, 0, -1, m);
    e = exp_q.pop_front();
    n_checks++;
    if (m.done_k !== e.done_k) begin
      n_fail++; $display("FAIL empty_done_k: got %0d want %0d", m.done_k, e.done_k);
    end
    n_checks++;
    if (m.n_mac !== e.n_mac || m.n_wr !== e.n_wr || m.n_buf !== e.n_buf) begin
      n_fail++; $display("FAIL empty_activity: mac=%0d wr=%0d buf=%0d want 0", m.n_mac, m.n_wr,
                         m.n_buf);
    end
    n_checks++;
    if (m.viol !== e.viol) begin
      n_fail++; $display("FAIL empty_cycle_rules: got %0d violations want %0d", m.viol, e.viol);
    end
  endtask

  task automatic test_taps_256();
    meas_t m, e;
    exp_q.push_back(model(0, 1, 0, 0));
    run_job(0, 1, 0, -1, -1, 0, -1, m);
    e = exp_q.pop_front();
    n_checks++;
    if (m.n_buf !== e.n_buf || m.n_mac !== e.n_mac) begin
      n_fail++; $display("FAIL taps256_buf_mac: got %0d/%0d want %0d/%0d", m.n_buf, m.n_mac,
                         e.n_buf, e.n_mac);
    end
    n_checks++;
    if (m.done_k !== e.done_k) begin
      n_fail++; $display("FAIL taps256_done_k: got %0d want %0d", m.done_k, e.done_k);
    end
  endtask

  task automatic test_reset_mid_drain();
    meas_t m, e;
    // k=9 is the second DRAIN cycle of a 3-tap single-pair job.
    run_job(3, 1, 0, -1, -1, 0, 9, m);
    n_checks++;
    if (m.n_wr !== 1 || m.n_buf !== 3) begin
      n_fail++; $display("FAIL abort_progress: wr=%0d buf=%0d want 1/3", m.n_wr, m.n_buf);
    end
    RST = 1'b1;
    @(posedge CLKEXT);
    #1;
    n_checks++;
    if (CON_SIG !== 16'h0000 || SSFR[10:0] !== 11'd0) begin
      n_fail++; $display("FAIL abort_outputs: con=%h ssfr=%h want 0000/low bits 0", CON_SIG, SSFR);
    end
    n_checks++;
    if ({IN_READY, BUSY, DONE} !== 3'b000) begin
      n_fail++; $display("FAIL abort_flags: got %b want 000", {IN_READY, BUSY, DONE});
    end
    RST = 1'b0; IN_VALID = 1'b0;
    exp_q.push_back(model(3, 1, 0, 0));
    run_job(3, 1, 0, -1, -1, 0, -1, m);
    e = exp_q.pop_front();
    n_checks++;
    if (m.done_k !== e.done_k || m.n_wr !== e.n_wr || m.n_shift !== e.n_shift) begin
      n_fail++; $display("FAIL abort_rerun: done=%0d wr=%0d shift=%0d want %0d/%0d/%0d",
                         m.done_k, m.n_wr, m.n_shift, e.done_k, e.n_wr, e.n_shift);
    end
    n_checks++;
    if (m.n_mac !== e.n_mac || m.viol !== e.viol) begin
      n_fail++; $display("FAIL abort_rerun_mac: mac=%0d viol=%0d want %0d/%0d", m.n_mac, m.viol,
                         e.n_mac, e.viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_valid();
    test_back_to_back();
    test_empty_job();
    test_taps_256();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
